// File: rtl/mem_responder.sv
// Memory-side responder for the LSU data port: valid/ready request, byte-masked write or
// word read, response after a programmable delay. MEM_RESPONDER_RANDLAT_EN adds LFSR jitter.
module mem_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h80000000,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg;
    logic        wen_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wmask_reg;
    logic        err_reg;
    logic        read_hit_reg;
    logic [31:0] mem_q;
    logic [31:0] mem [2**DEPTH_LOG2];

    logic        accept;
    logic        commit;
    logic [31:0] cmd_addr;
    logic        cmd_wen;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic [31:0] offset;
    logic        in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic [7:0]  wait_cnt;

    assign req_ready = (state_reg == IDLE) && rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = read_hit_reg ? mem_q : 32'd0;
    assign rsp_err   = err_reg;

    // With zero wait the commit happens on the accept edge, so use the live request.
    assign cmd_addr  = (state_reg == IDLE) ? req_addr       : addr_reg;
    assign cmd_wen   = (state_reg == IDLE) ? req_wen        : wen_reg;
    assign cmd_wdata = (state_reg == IDLE) ? req_wdata      : wdata_reg;
    assign cmd_wmask = (state_reg == IDLE) ? req_wmask[3:0] : wmask_reg;

    assign offset   = cmd_addr - BASE_ADDR;
    assign in_range = (cmd_addr >= BASE_ADDR) && (offset[31:DEPTH_LOG2+2] == '0);
    assign idx      = offset[DEPTH_LOG2+1:2];

`ifdef MEM_RESPONDER_RANDLAT_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    assign wait_cnt = 8'(LATENCY) + {5'd0, lfsr_reg[2:0]};
`else
    assign wait_cnt = 8'(LATENCY);
`endif

    logic unused_bits;
    assign unused_bits = ^{req_wmask[7:4], offset[1:0]};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (wait_cnt == 8'd0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = wait_cnt;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 8'd1;
                if (cnt_reg <= 8'd1) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            addr_reg     <= 32'd0;
            wen_reg      <= 1'b0;
            wdata_reg    <= 32'd0;
            wmask_reg    <= 4'd0;
            err_reg      <= 1'b0;
            read_hit_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg  <= req_addr;
                wen_reg   <= req_wen;
                wdata_reg <= req_wdata;
                wmask_reg <= req_wmask[3:0];
            end
            if (commit) begin
                err_reg      <= !in_range;
                read_hit_reg <= in_range && !cmd_wen;
            end
        end
    end

    // Array has no reset; commit cannot fire while rst is low because req_ready is held off.
    always_ff @(posedge clk) begin
        if (commit && in_range) begin
            if (cmd_wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (cmd_wmask[b]) begin
                        mem[idx][b*8 +: 8] <= cmd_wdata[b*8 +: 8];
                    end
                end
            end else begin
                mem_q <= mem[idx];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-map reference model.
// Define MEM_RESPONDER_RANDLAT_EN for both files to exercise the jittered latency.
module tb_mem_responder;

    localparam logic [31:0] BASE       = 32'h80000000;
    localparam int          DEPTH_LOG2 = 12;
    localparam int          LATENCY    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        req_wen = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic [7:0]  req_wmask = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [int unsigned];

    mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .BASE_ADDR(BASE), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit addr_err(input logic [31:0] a);
        return (a < BASE) || (((a - BASE) >> 2) >= (32'd1 << DEPTH_LOG2));
    endfunction

    function automatic int unsigned word_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Issues one request from a negedge and returns at the negedge after the response handshake.
    task automatic do_op(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [7:0] wm, input int hold,
                         output logic [31:0] rd, output logic er, output int lat, output bit ok);
        int n;
        ok = 0; lat = 0; rd = 32'd0; er = 1'b0; n = 0;
        req_addr = a; req_wen = w; req_wdata = wd; req_wmask = wm;
        req_valid = 1'b1; rsp_ready = 1'b0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'(rsp_valid), 32'd1);
            return;
        end
        rd = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, rd);
            check("hold_err", 32'(rsp_err), 32'(er));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("req_ready_after", 32'(req_ready), 32'd1);
        ok = 1;
    endtask

    // One transaction checked against the reference model; the model is updated on writes.
    task automatic xact(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [7:0] wm, input int hold,
                        output logic [31:0] rd, output logic er);
        bit          exp_er;
        int unsigned wi;
        int          lat;
        bit          ok;
        exp_er = addr_err(a);
        wi = exp_er ? 0 : word_of(a);
        do_op(a, w, wd, wm, hold, rd, er, lat, ok);
        $display("op %s addr=%h wdata=%h mask=%h -> rdata=%h err=%0d lat=%0d",
                 w ? "WR" : "RD", a, wd, wm, rd, er, lat);
        if (!ok) return;
        check("rsp_err", 32'(er), 32'(exp_er));
`ifdef MEM_RESPONDER_RANDLAT_EN
        check("latency_range", 32'((lat >= LATENCY + 1) && (lat <= LATENCY + 8)), 32'd1);
`else
        check("latency", 32'(lat), 32'(LATENCY + 1));
`endif
        if (w || exp_er) begin
            check("rdata_zero", rd, 32'd0);
        end else if (model.exists(wi)) begin
            check("rdata", rd, model[wi]);
        end
        if (w && !exp_er) begin
            logic [31:0] word;
            word = model.exists(wi) ? model[wi] : 32'd0;
            for (int b = 0; b < 4; b++)
                if (wm[b]) word[b*8 +: 8] = wd[b*8 +: 8];
            model[wi] = word;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;

        // Reset held with a pending request
        req_valid = 1'b1;
        req_wen = 1'b1;
        req_addr = BASE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_rdata", rsp_rdata, 32'd0);
            check("rst_rsp_err", 32'(rsp_err), 32'd0);
        end
        req_valid = 1'b0;
        req_wen = 1'b0;
        rst = 1'b1;
        #1;
        check("req_ready_after_release", 32'(req_ready), 32'd1);
        @(negedge clk);

        // Give the first 16 words known contents
        for (int i = 0; i < 16; i++)
            xact(BASE + 32'(i * 4), 1'b1, $urandom, 8'hFF, 0, rd, er);

        xact(32'h80000010, 1'b1, 32'hDEADBEEF, 8'h0F, 0, rd, er);
        check("wr_err", 32'(er), 32'd0);
        xact(32'h80000010, 1'b0, 32'd0, 8'h00, 0, rd, er);
        check("rd_deadbeef", rd, 32'hDEADBEEF);
        xact(32'h80000010, 1'b1, 32'h11223344, 8'h05, 0, rd, er);
        xact(32'h80000010, 1'b0, 32'd0, 8'h00, 0, rd, er);
        check("mask05", rd, 32'hDE22BE44);
        xact(32'h80000010, 1'b1, 32'h55667788, 8'hF0, 0, rd, er);
        xact(32'h80000010, 1'b0, 32'd0, 8'h00, 0, rd, er);
        check("maskF0", rd, 32'hDE22BE44);

        xact(32'h7FFFFFFC, 1'b0, 32'd0, 8'h00, 0, rd, er);
        check("oor_low_err", 32'(er), 32'd1);
        check("oor_low_rdata", rd, 32'd0);
        xact(32'h80004000, 1'b1, 32'h12345678, 8'h0F, 0, rd, er);
        check("oor_high_err", 32'(er), 32'd1);
        xact(32'h80000000, 1'b0, 32'd0, 8'h00, 0, rd, er);

        // Response backpressure
        xact(32'h80000010, 1'b0, 32'd0, 8'h00, 5, rd, er);
        check("bp_rdata", rd, 32'hDE22BE44);

        // Reset while a write sits in WAIT
        req_addr = 32'h80000020; req_wen = 1'b1; req_wdata = 32'hCAFEF00D; req_wmask = 8'h0F;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("midop_no_rsp", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midop_rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("midop_ready_release", 32'(req_ready), 32'd1);
        @(negedge clk);
        xact(32'h80000020, 1'b0, 32'd0, 8'h00, 0, rd, er);

        // Random mix over the known window plus out-of-range addresses
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'h7FFFFFF0 + 32'($urandom_range(0, 15));
                1:       a = 32'h80004000 + 32'($urandom_range(0, 63));
                2:       a = 32'hFFFFFFFC - 32'($urandom_range(0, 3));
                default: a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            endcase
            xact(a, 1'($urandom_range(0, 1)), $urandom, 8'($urandom), $urandom_range(0, 2), rd, er);
        end

`ifdef MEM_RESPONDER_RANDLAT_EN
        for (int i = 0; i < 100; i++)
            xact(BASE + 32'($urandom_range(0, 15) * 4), 1'b0, 32'd0, 8'h00, 0, rd, er);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's load/store data port.
- Accepts one request at a time over a valid/ready request channel and performs a byte-masked write or a word read against an internal word-addressed array.
- Returns the result over a valid/ready response channel after a programmable latency.
- Replaces the zero-latency combinational memory path, so the core's multi-cycle LSU can be developed and verified against realistic timing.

Parameters:
- DEPTH_LOG2, 12, log2 of number of 32-bit words in the array.
- BASE_ADDR, 32'h80000000, byte address mapped to word 0.
- LATENCY, 2, cycles spent in WAIT between accept and response (0 allowed).

Ports:
- clk  in  1  clock, rising edge active.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wen  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- req_wmask  in  8  byte enables; bit i enables byte i for i<4; bits [7:4] ignored.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  32  read data (0 for writes and errors).
- rsp_err  out  1  address outside mapped range.

Behaviour:
- Reset (rst low, async): state=IDLE; req_ready=0 while rst is low; rsp_valid=0, rsp_rdata=0, rsp_err=0; delay counter cleared. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Handshake on req_valid&&req_ready latches addr, wen, wdata and wmask[3:0].
  - Next state: WAIT with counter=LATENCY, or RESP directly if LATENCY=0 (data is then presented the cycle after accept).
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter reaches 1, next state is RESP.
  - Total accept-to-rsp_valid latency = LATENCY+1 cycles.
- Entering RESP (single edge):
  - Range check: index=(addr-BASE_ADDR)>>2. Error if addr<BASE_ADDR or index>=2^DEPTH_LOG2.
  - Error: rsp_err=1, rsp_rdata=0, no array write.
  - Valid write: array[index] byte i <= wdata byte i for each set mask bit; rsp_rdata=0.
  - Valid read: rsp_rdata=array[index] (pre-write value is irrelevant since only one op is in flight).
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until the rsp_valid&&rsp_ready handshake.
  - On handshake: next state IDLE, rsp_valid=0. req_ready rises the cycle after the response handshake (no same-cycle turnaround).
- Write with wmask[3:0]=0: legal no-op, response still returned.
- Address wrap: arithmetic is 32-bit unsigned. Addresses below BASE_ADDR are flagged as error; wrap is never treated as in-range.
- Reset mid-operation: FSM returns to IDLE. A write not yet committed (still in WAIT) is discarded. A write committed before reset stays in the array.
- req_valid held high while not ready: ignored; requester must hold its request stable.

Optional Feature:
- Macro MEM_RESPONDER_RANDLAT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every clock.
  - On each accept, the WAIT count is LATENCY + lfsr[2:0] (0..7 extra cycles), for stressing the core's stall logic.
  - LFSR state is observable only through timing.
- Undefined: fixed latency LATENCY; no LFSR logic is synthesized.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 throughout; req_ready=1 in the first cycle after release.
- Write then read, LATENCY=2: write addr 32'h80000010, wdata 32'hDEADBEEF, wmask 8'h0F -> rsp_valid exactly 3 cycles after accept, rsp_err=0. Read same address -> rsp_rdata=32'hDEADBEEF.
- Byte mask: write 32'h11223344 mask 8'h05 over 32'hDEADBEEF at the same address, then read -> 32'hDE22BE44. Mask 8'hF0 -> word unchanged.
- Out of range:
  - Read 32'h7FFFFFFC -> rsp_err=1, rsp_rdata=0.
  - Write 32'h80004000 (DEPTH_LOG2=12) -> rsp_err=1, and a subsequent read of 32'h80000000 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata stable, req_ready=0. Raise rsp_ready -> rsp_valid drops next cycle, req_ready=1.
- Reset mid-op: accept write of 32'hCAFEF00D to 32'h80000020, assert rst in WAIT -> after release, read returns the prior contents, and the FSM accepts immediately. With MEM_RESPONDER_RANDLAT_EN, latency across 100 reads always falls in 3..10 cycles.
